// File: rtl/ctrl_pkg.sv
// Shared widths, instruction-word sizing and loader FSM encoding for the controller slice.
package ctrl_pkg;

  localparam int DEF_VEC_ID_WIDTH       = 3;
  localparam int DEF_REGFILE_ADDR_WIDTH = 4;
  localparam int DEF_DATA_ADDR_WIDTH    = 6;
  localparam int DEF_INSTR_ADDR_WIDTH   = 5;

  // opcode(2) + vector id + two regfile addresses + three data/coef addresses
  function automatic int instr_width(input int vec_w, input int rf_w, input int da_w);
    return 2 + vec_w + 2 * rf_w + 3 * da_w;
  endfunction

  localparam int DEF_INSTR_WIDTH =
    instr_width(DEF_VEC_ID_WIDTH, DEF_REGFILE_ADDR_WIDTH, DEF_DATA_ADDR_WIDTH);
  localparam int DEF_PROG_SIZE = 2 ** DEF_INSTR_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_ERR   = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/prog_ram.sv
// Program store: one write port, one enabled registered read port, no reset on contents.
// Read data updates one edge after rd_en and holds while rd_en is low.
module prog_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a program over a valid/ready stream into prog_ram and serves controller fetches.
// Fetch latency 1; ld_ready is high only while loading, so the source stalls otherwise.
module prog_loader #(
  parameter int VEC_ID_WIDTH       = ctrl_pkg::DEF_VEC_ID_WIDTH,
  parameter int REGFILE_ADDR_WIDTH = ctrl_pkg::DEF_REGFILE_ADDR_WIDTH,
  parameter int DATA_ADDR_WIDTH    = ctrl_pkg::DEF_DATA_ADDR_WIDTH,
  parameter int INSTR_ADDR_WIDTH   = ctrl_pkg::DEF_INSTR_ADDR_WIDTH,
  localparam int INSTR_WIDTH =
    ctrl_pkg::instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prog,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [INSTR_WIDTH-1:0]      ld_data,
  input  logic                        ld_last,
  input  logic                        fetch,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc,
  output logic [INSTR_WIDTH-1:0]      instr_word,
  output logic [INSTR_ADDR_WIDTH:0]   prog_len,
  output logic                        loaded,
  output logic                        ovf_err
);

  import ctrl_pkg::*;

  localparam logic [INSTR_ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [INSTR_ADDR_WIDTH-1:0] PTR_ONE = INSTR_ADDR_WIDTH'(1);
  localparam logic [INSTR_ADDR_WIDTH:0]   CNT_ONE = (INSTR_ADDR_WIDTH + 1)'(1);

  ldr_state_t                  state;
  logic                        prog_q;
  logic [INSTR_ADDR_WIDTH-1:0] wr_ptr;
  logic [INSTR_ADDR_WIDTH:0]   count;
  logic                        zero_sel;
  logic                        prog_rise;
  logic                        xfer;
  logic                        fetch_go;
  logic [INSTR_WIDTH-1:0]      ram_rd_data;

  assign ld_ready  = (state == ST_LOAD);
  assign xfer      = ld_valid & ld_ready;
  assign prog_rise = prog & ~prog_q;
  // A fresh load request pre-empts a fetch arriving in the same cycle.
  assign fetch_go  = (state == ST_READY) & fetch & ~prog_rise;

  // zero_sel masks the RAM output for out-of-range fetches and after reset.
  assign instr_word = zero_sel ? '0 : ram_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      prog_q   <= 1'b0;
      wr_ptr   <= '0;
      count    <= '0;
      prog_len <= '0;
      loaded   <= 1'b0;
      ovf_err  <= 1'b0;
      zero_sel <= 1'b1;
    end else begin
      prog_q <= prog;
      if (fetch_go) zero_sel <= ({1'b0, pc} >= prog_len);

      unique case (state)
        ST_IDLE, ST_READY, ST_ERR: begin
          if (prog_rise) begin
            state    <= ST_LOAD;
            wr_ptr   <= '0;
            count    <= '0;
            prog_len <= '0;
            loaded   <= 1'b0;
            ovf_err  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (xfer && ld_last) begin
            state    <= ST_READY;
            prog_len <= count + CNT_ONE;
            count    <= count + CNT_ONE;
            loaded   <= 1'b1;
            if (wr_ptr != PTR_MAX) wr_ptr <= wr_ptr + PTR_ONE;
          end else if (xfer && wr_ptr == PTR_MAX) begin
            // Last slot filled without a terminator: pointer stays put.
            state   <= ST_ERR;
            count   <= count + CNT_ONE;
            ovf_err <= 1'b1;
          end else if (!prog) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            count  <= '0;
          end else if (xfer) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  prog_ram #(
    .ADDR_WIDTH (INSTR_ADDR_WIDTH),
    .DATA_WIDTH (INSTR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (xfer),
    .wr_addr (wr_ptr),
    .wr_data (ld_data),
    .rd_en   (fetch_go),
    .rd_addr (pc),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: queue-based program model checked every cycle plus literal pins.
module tb_prog_loader;

  import ctrl_pkg::*;

  localparam int IW = DEF_INSTR_WIDTH;
  localparam int AW = DEF_INSTR_ADDR_WIDTH;
  localparam int PS = DEF_PROG_SIZE;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog;
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          fetch;
  logic [AW-1:0] pc;
  logic [IW-1:0] instr_word;
  logic [AW:0]   prog_len;
  logic          loaded;
  logic          ovf_err;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .prog       (prog),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .fetch      (fetch),
    .pc         (pc),
    .instr_word (instr_word),
    .prog_len   (prog_len),
    .loaded     (loaded),
    .ovf_err    (ovf_err)
  );

  // Model: the program is a queue of accepted words; modes are plain flags.
  logic [IW-1:0] m_prog[$];
  logic [IW-1:0] m_word      = '0;
  bit            m_load      = 1'b0;
  bit            m_ready     = 1'b0;
  bit            m_ovf       = 1'b0;
  bit            m_prog_prev = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_load = 1'b0; m_ready = 1'b0; m_ovf = 1'b0;
      m_word = '0; m_prog_prev = 1'b0; m_prog.delete();
    end else begin
      bit rise;
      rise = prog && !m_prog_prev;
      m_prog_prev = prog;
      if (!m_load && rise) begin
        m_load = 1'b1; m_ready = 1'b0; m_ovf = 1'b0; m_prog.delete();
      end else if (m_load) begin
        if (ld_valid) begin
          m_prog.push_back(ld_data);
          if (ld_last) begin
            m_load = 1'b0; m_ready = 1'b1;
          end else if (m_prog.size() == PS) begin
            m_load = 1'b0; m_ovf = 1'b1;
          end else if (!prog) begin
            m_load = 1'b0; m_prog.delete();
          end
        end else if (!prog) begin
          m_load = 1'b0; m_prog.delete();
        end
      end else if (m_ready && fetch) begin
        m_word = (int'(pc) < m_prog.size()) ? m_prog[pc] : '0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ld_ready", ld_ready, m_load);
      check("cyc_loaded", loaded, m_ready);
      check("cyc_ovf_err", ovf_err, m_ovf);
      check("cyc_prog_len", prog_len, m_ready ? m_prog.size() : 0);
      check("cyc_instr_word", instr_word, m_word);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [IW-1:0] d, input logic last);
    bit ok;
    bit done;
    done = 1'b0;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      ok = ld_ready;
      step();
      done = ok;
    end
    if (!done) begin
      failures++;
      $display("FAIL send_timeout: ld_ready=0 required=1 for word %0h", d);
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = IW'($urandom);
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    fetch = 1'b1; pc = a;
    step();
    fetch = 1'b0;
  endtask

  task automatic restart();
    prog = 1'b0; step();
    prog = 1'b1; step();
  endtask

  initial begin
    rst = 1'b1; prog = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; fetch = 1'b0; pc = '0;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_instr", instr_word, 0);
    check("rst_prog_len", prog_len, 0);
    check("rst_loaded", loaded, 0);
    check("rst_ovf", ovf_err, 0);
    step();
    rst = 1'b0; prog = 1'b1;
    step();

    // Four words with ld_valid toggling, prog held high afterwards.
    for (int i = 1; i <= 4; i++) begin
      send(IW'(i), i == 4);
      if (i < 4) step();
    end
    @(negedge clk);
    check("load4_loaded", loaded, 1);
    check("load4_len", prog_len, 4);
    check("load4_ld_ready", ld_ready, 0);
    step();
    do_fetch(5'd2);
    @(negedge clk); check("fetch_pc2", instr_word, 31'h3);
    step();
    do_fetch(5'd7);
    @(negedge clk); check("fetch_pc7", instr_word, 0);
    step();
    do_fetch(5'd0);
    @(negedge clk); check("fetch_pc0", instr_word, 31'h1);
    pc = 5'd3;
    step(); step();
    @(negedge clk);
    check("hold_no_fetch", instr_word, 31'h1);
    check("prog_held_no_reload", ld_ready, 0);
    step();

    // Load request and fetch in the same cycle.
    prog = 1'b0; step();
    prog = 1'b1; fetch = 1'b1; pc = 5'd1;
    step();
    fetch = 1'b0;
    @(negedge clk);
    check("pre_ld_ready", ld_ready, 1);
    check("pre_loaded", loaded, 0);
    check("pre_instr", instr_word, 31'h1);
    step();

    // Overflow: 32 words with no terminator.
    for (int i = 0; i < PS; i++) send(IW'(100 + i), 1'b0);
    @(negedge clk);
    check("ovf_flag", ovf_err, 1);
    check("ovf_loaded", loaded, 0);
    check("ovf_ld_ready", ld_ready, 0);
    ld_valid = 1'b1; step(); step(); ld_valid = 1'b0;
    @(negedge clk); check("ovf_holds", ovf_err, 1);
    step();
    restart();
    @(negedge clk);
    check("ovf_cleared", ovf_err, 0);
    check("reload_ld_ready", ld_ready, 1);

    // Abort after 2 of 5 words, then a 3-word program.
    send(IW'(11), 1'b0);
    send(IW'(22), 1'b0);
    prog = 1'b0; step();
    @(negedge clk);
    check("abort_loaded", loaded, 0);
    check("abort_len", prog_len, 0);
    check("abort_ld_ready", ld_ready, 0);
    step();
    prog = 1'b1; step();
    send(IW'(5), 1'b0);
    send(IW'(6), 1'b0);
    send(IW'(7), 1'b1);
    @(negedge clk); check("load3_len", prog_len, 3);
    step();
    do_fetch(5'd2);
    @(negedge clk); check("load3_pc2", instr_word, 31'h7);
    step();
    do_fetch(5'd3);
    @(negedge clk); check("load3_pc3", instr_word, 0);
    step();

    // Full 32-word program terminated on the final slot.
    restart();
    for (int i = 0; i < PS; i++) send(IW'(i * 3 + 1), i == PS - 1);
    @(negedge clk);
    check("full_len", prog_len, 32);
    check("full_loaded", loaded, 1);
    check("full_ovf", ovf_err, 0);
    step();
    do_fetch(5'd31);
    @(negedge clk); check("full_pc31", instr_word, 31'h5e);
    step();

    // Asynchronous reset in the middle of a load.
    restart();
    send(IW'(31'h55), 1'b0);
    rst = 1'b1; prog = 1'b0;
    #1;
    check("arst_ld_ready", ld_ready, 0);
    check("arst_loaded", loaded, 0);
    check("arst_len", prog_len, 0);
    check("arst_ovf", ovf_err, 0);
    check("arst_instr", instr_word, 0);
    step();
    rst = 1'b0;
    step();
    do_fetch(5'd0);
    @(negedge clk);
    check("post_rst_instr", instr_word, 0);
    check("post_rst_loaded", loaded, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
